// File: rtl/taylor_stream_feeder_if.sv
// ---------------------------------------------------------------------------
// taylor_stream_feeder_if
//
// Host-side bus of the Taylor stream feeder: the sample valid/ready handshake
// and the coefficient-table write port.
//
// Signals:
//   sample_valid_i  host -> feeder  sample handshake valid
//   sample_data_i   host -> feeder  IEEE-754 single-precision sample word
//   sample_ready_o  feeder -> host  sample handshake ready
//   coeff_we_i      host -> feeder  coefficient write enable
//   coeff_waddr_i   host -> feeder  coefficient index (0 = constant term)
//   coeff_wdata_i   host -> feeder  coefficient word
//   coeff_wr_err_o  feeder -> host  one-cycle pulse when a write was dropped
//
// Modports:
//   master  host / DMA side
//   slave   feeder side
// ---------------------------------------------------------------------------
interface taylor_stream_feeder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_LINES = 5
);

  logic                  sample_valid_i;
  logic [DATA_WIDTH-1:0] sample_data_i;
  logic                  sample_ready_o;
  logic                  coeff_we_i;
  logic [ADDR_LINES-1:0] coeff_waddr_i;
  logic [DATA_WIDTH-1:0] coeff_wdata_i;
  logic                  coeff_wr_err_o;

  modport master (
    output sample_valid_i,
    output sample_data_i,
    input  sample_ready_o,
    output coeff_we_i,
    output coeff_waddr_i,
    output coeff_wdata_i,
    input  coeff_wr_err_o
  );

  modport slave (
    input  sample_valid_i,
    input  sample_data_i,
    output sample_ready_o,
    input  coeff_we_i,
    input  coeff_waddr_i,
    input  coeff_wdata_i,
    output coeff_wr_err_o
  );

endinterface

// File: rtl/taylor_stream_feeder.sv
// ---------------------------------------------------------------------------
// taylor_stream_feeder
//
// Upstream feeder for the mac Taylor-series engine. Buffers incoming
// single-precision samples and holds a writable coefficient table. On start
// it streams the buffered samples (in arrival order) on signal_fifo_o, then
// the coefficients from the highest order down to the constant term on
// coeff_fifo_o, one word per cycle. Each stream is terminated by the
// NAN_SENTINEL word, which the bus keeps driving until the next run.
//
// Ports:
//   clk_i            clock
//   rstn_i           asynchronous active-low reset
//   bus              taylor_stream_feeder_if.slave (sample handshake and
//                    coefficient write port)
//   start_i          begin streaming (ignored unless idle)
//   taylor_length_i  highest coefficient order L for the next run
//   signal_fifo_o    sample stream to the mac signal_fifo
//   coeff_fifo_o     coefficient stream to the mac coeff_fifo
//   taylor_length_o  L latched at start, to the mac taylor_length
//   busy_o           streaming in progress
//   done_o           one-cycle completion pulse
//   sample_count_o   number of samples currently buffered
//
// Build option:
//   FEEDER_NAN_SCRUB_EN  when defined, accepted samples that are NaN
//                        (exponent all ones, mantissa nonzero) are stored as
//                        +0.0 so they can never terminate the mac stream
//                        early. Undefined: samples are stored unmodified.
// ---------------------------------------------------------------------------
module taylor_stream_feeder #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    ADDR_LINES   = 5,
  parameter logic [DATA_WIDTH-1:0] NAN_SENTINEL = 32'h7F900000
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  taylor_stream_feeder_if.slave   bus,
  input  logic                    start_i,
  input  logic [ADDR_LINES-1:0]   taylor_length_i,
  output logic [DATA_WIDTH-1:0]   signal_fifo_o,
  output logic [DATA_WIDTH-1:0]   coeff_fifo_o,
  output logic [ADDR_LINES-1:0]   taylor_length_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [ADDR_LINES:0]     sample_count_o
);

  localparam int DEPTH = 2 ** ADDR_LINES;

  // Count value meaning "buffer full" (exactly 2**ADDR_LINES samples).
  localparam logic [ADDR_LINES:0]   FULL_COUNT = {1'b1, {ADDR_LINES{1'b0}}};
  localparam logic [ADDR_LINES:0]   CNT_ONE    = {{ADDR_LINES{1'b0}}, 1'b1};
  localparam logic [ADDR_LINES-1:0] IDX_ONE    = {{(ADDR_LINES-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_SIG,
    S_SIG_END,
    S_SEND_COEF,
    S_COEF_END,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_LINES:0]   count_q, count_d;
  logic [ADDR_LINES:0]   rd_idx_q, rd_idx_d;
  logic [ADDR_LINES-1:0] coef_idx_q, coef_idx_d;
  logic [ADDR_LINES-1:0] length_q, length_d;
  logic [DATA_WIDTH-1:0] sig_q, sig_d;
  logic [DATA_WIDTH-1:0] coef_q, coef_d;
  logic                  wr_err_q, wr_err_d;

  logic [DATA_WIDTH-1:0] sample_mem  [DEPTH];
  logic [DATA_WIDTH-1:0] coeff_table [DEPTH];

  logic                  sample_ready;
  logic                  sample_hs;
  logic                  coef_locked;
  logic                  coeff_wr_ok;
  logic [DATA_WIDTH-1:0] sample_word;
  logic [DATA_WIDTH-1:0] sample_rd;
  logic [ADDR_LINES-1:0] coeff_rd_addr;
  logic [DATA_WIDTH-1:0] coeff_rd;

  // Samples are only taken while idle and while there is room left.
  assign sample_ready = (state_q == S_IDLE) && (count_q < FULL_COUNT);
  assign sample_hs    = bus.sample_valid_i && sample_ready;

  // The table is being read out during SEND_COEF/COEF_END, so writes there
  // are refused to keep the streamed polynomial consistent.
  assign coef_locked  = (state_q == S_SEND_COEF) || (state_q == S_COEF_END);
  assign coeff_wr_ok  = bus.coeff_we_i && !coef_locked;

`ifdef FEEDER_NAN_SCRUB_EN
  // A NaN sample could look like a terminator to the mac, so store +0.0.
  assign sample_word =
    ((bus.sample_data_i[DATA_WIDTH-2 -: 8] == 8'hFF) &&
     (bus.sample_data_i[DATA_WIDTH-10:0] != '0)) ? '0 : bus.sample_data_i;
`else
  assign sample_word = bus.sample_data_i;
`endif

  // rd_idx_q always points at the next sample to emit; it is 0 while idle,
  // so the same read port supplies the first word at start.
  assign sample_rd = sample_mem[rd_idx_q[ADDR_LINES-1:0]];

  // SIG_END prefetches coeff[L]; SEND_COEF walks down from there. A write
  // accepted in SIG_END to the very entry being fetched is forwarded so the
  // new value is the one streamed.
  assign coeff_rd_addr = (state_q == S_SIG_END) ? length_q : (coef_idx_q - IDX_ONE);
  assign coeff_rd = (coeff_wr_ok && (bus.coeff_waddr_i == coeff_rd_addr)) ?
                    bus.coeff_wdata_i : coeff_table[coeff_rd_addr];

  // Next-state and next-output logic. Output words are registered, so the
  // word chosen here appears on the bus in the cycle after the decision.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rd_idx_d   = rd_idx_q;
    coef_idx_d = coef_idx_q;
    length_d   = length_q;
    sig_d      = sig_q;
    coef_d     = coef_q;
    wr_err_d   = bus.coeff_we_i && coef_locked;

    if (sample_hs) begin
      count_d = count_q + CNT_ONE;
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          length_d = taylor_length_i;
          if (count_q != '0) begin
            state_d  = S_SEND_SIG;
            sig_d    = sample_rd;
            rd_idx_d = CNT_ONE;
          end else if (sample_hs) begin
            // The only sample is the one arriving with start; pass it on
            // directly while it is being written into the buffer.
            state_d  = S_SEND_SIG;
            sig_d    = sample_word;
            rd_idx_d = CNT_ONE;
          end else begin
            state_d = S_SIG_END;
            sig_d   = NAN_SENTINEL;
          end
        end
      end

      S_SEND_SIG: begin
        if (rd_idx_q == count_q) begin
          state_d = S_SIG_END;
          sig_d   = NAN_SENTINEL;
        end else begin
          sig_d    = sample_rd;
          rd_idx_d = rd_idx_q + CNT_ONE;
        end
      end

      S_SIG_END: begin
        state_d    = S_SEND_COEF;
        coef_d     = coeff_rd;
        coef_idx_d = length_q;
      end

      S_SEND_COEF: begin
        if (coef_idx_q == '0) begin
          state_d = S_COEF_END;
          coef_d  = NAN_SENTINEL;
        end else begin
          coef_d     = coeff_rd;
          coef_idx_d = coef_idx_q - IDX_ONE;
        end
      end

      S_COEF_END: begin
        state_d = S_DONE;
      end

      S_DONE: begin
        state_d  = S_IDLE;
        count_d  = '0;
        rd_idx_d = '0;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and output registers; reset drops any run in progress.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      rd_idx_q   <= '0;
      coef_idx_q <= '0;
      length_q   <= '0;
      sig_q      <= '0;
      coef_q     <= '0;
      wr_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rd_idx_q   <= rd_idx_d;
      coef_idx_q <= coef_idx_d;
      length_q   <= length_d;
      sig_q      <= sig_d;
      coef_q     <= coef_d;
      wr_err_q   <= wr_err_d;
    end
  end

  // Sample storage needs no reset: entries at or above count_q are never
  // read, so clearing the count empties the buffer.
  always_ff @(posedge clk_i) begin
    if (sample_hs) begin
      sample_mem[count_q[ADDR_LINES-1:0]] <= sample_word;
    end
  end

  // Coefficient table is cleared on reset so a fresh run streams zeros.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        coeff_table[i] <= '0;
      end
    end else if (coeff_wr_ok) begin
      coeff_table[bus.coeff_waddr_i] <= bus.coeff_wdata_i;
    end
  end

  assign bus.sample_ready_o = sample_ready;
  assign bus.coeff_wr_err_o = wr_err_q;

  assign signal_fifo_o   = sig_q;
  assign coeff_fifo_o    = coef_q;
  assign taylor_length_o = length_q;
  assign busy_o          = (state_q == S_SEND_SIG)  || (state_q == S_SIG_END) ||
                           (state_q == S_SEND_COEF) || (state_q == S_COEF_END);
  assign done_o          = (state_q == S_DONE);
  assign sample_count_o  = count_q;

endmodule
